// File: rtl/sigma_xif_timer_pkg.sv
// Shared constants, register map and control payload for the xif timer/compare peripheral.
// Feature macro SIGMA_XIF_TIMER_CAPTURE_EN is consumed by the top, not here.
package sigma_xif_timer_pkg;

  localparam int unsigned TMR_DATA_W = 32;
  localparam int unsigned TMR_WIN_W  = 5;

  localparam logic [TMR_WIN_W-1:0] TMR_CTRL_OFFS    = 5'h00;
  localparam logic [TMR_WIN_W-1:0] TMR_PRESC_OFFS   = 5'h04;
  localparam logic [TMR_WIN_W-1:0] TMR_COUNT_OFFS   = 5'h08;
  localparam logic [TMR_WIN_W-1:0] TMR_COMPARE_OFFS = 5'h0C;
  localparam logic [TMR_WIN_W-1:0] TMR_STATUS_OFFS  = 5'h10;
  localparam logic [TMR_WIN_W-1:0] TMR_CAPTURE_OFFS = 5'h14;

  localparam int unsigned TMR_CTRL_EN_BIT         = 0;
  localparam int unsigned TMR_CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned TMR_CTRL_IRQ_EN_BIT     = 2;
  localparam int unsigned TMR_STATUS_MATCH_BIT    = 0;
  localparam int unsigned TMR_STATUS_CAPT_BIT     = 1;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } tmr_ctrl_t;

  // Merge write data into a current register value under byte enables.
  function automatic logic [TMR_DATA_W-1:0] tmr_apply_be(input logic [TMR_DATA_W-1:0] cur,
                                                         input logic [TMR_DATA_W-1:0] wdata,
                                                         input logic [3:0]            be);
    logic [TMR_DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sigma_xif_timer_presc.sv
// Prescaler: counts 0..limit while enabled and pulses tick on the terminal count.
module sigma_xif_timer_presc #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en,
  input  logic [PRESC_W-1:0] limit,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = en & (pcnt_q == limit);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/sigma_xif_timer.sv
// xif-attached timer/compare peripheral: prescaled 32-bit counter, compare match, level irq.
// Optional input capture is enabled by defining SIGMA_XIF_TIMER_CAPTURE_EN.
module sigma_xif_timer
  import sigma_xif_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h80000010,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef SIGMA_XIF_TIMER_CAPTURE_EN
  input  logic        capture_i,
`endif
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        irq_o
);

  logic [31:0]          offs;
  logic [TMR_WIN_W-1:0] reg_offs;
  logic                 in_win, wr_en, rd_en, unused_offs_lsb;
  logic [31:0]          reg_rd, wr_merged;
  logic                 tick, hit, presc_clr, clr_match;
  logic                 capt_rd;
  logic [31:0]          capture_rd;

  tmr_ctrl_t            ctrl_q, ctrl_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [31:0]          count_q, count_d, compare_q, compare_d, rdata_q, rdata_d;
  logic                 match_q, match_d, resp_q, resp_d, irq_q, irq_d;

  // Unsigned offset from base: below-base addresses wrap high and fall outside the window.
  assign offs            = bus_addr_bi - BASE_ADDR;
  assign in_win          = (offs[31:TMR_WIN_W] == '0);
  assign reg_offs        = {offs[TMR_WIN_W-1:2], 2'b00};
  assign unused_offs_lsb = ^offs[1:0];
  assign wr_en           = bus_req_i & bus_we_i & in_win;
  assign rd_en           = bus_req_i & ~bus_we_i & in_win;
  assign bus_ack_o       = bus_req_i;

  sigma_xif_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (ctrl_q.en),
    .limit  (presc_q),
    .clr    (presc_clr),
    .tick   (tick)
  );

`ifdef SIGMA_XIF_TIMER_CAPTURE_EN
  logic [2:0]  cap_sync_q, cap_sync_d;
  logic        capt_q, capt_d, cap_rise, clr_capt;
  logic [31:0] capture_q, capture_d;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_comb begin
    cap_sync_d = {cap_sync_q[1:0], capture_i};
    cap_rise   = cap_sync_q[1] & ~cap_sync_q[2];
    clr_capt   = wr_en & (reg_offs == TMR_STATUS_OFFS) & bus_be_bi[0]
                 & bus_wdata_bi[TMR_STATUS_CAPT_BIT];
    capture_d  = cap_rise ? count_q : capture_q;
    capt_d     = (capt_q & ~clr_capt) | cap_rise;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cap_sync_q <= '0;
      capt_q     <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_sync_q <= cap_sync_d;
      capt_q     <= capt_d;
      capture_q  <= capture_d;
    end
  end

  assign capt_rd    = capt_q;
  assign capture_rd = capture_q;
`else
  assign capt_rd    = 1'b0;
  assign capture_rd = '0;
`endif

  // Register read mux, also the base value for byte-enable merges.
  always_comb begin
    reg_rd = '0;
    case (reg_offs)
      TMR_CTRL_OFFS: begin
        reg_rd[TMR_CTRL_EN_BIT]         = ctrl_q.en;
        reg_rd[TMR_CTRL_AUTORELOAD_BIT] = ctrl_q.autoreload;
        reg_rd[TMR_CTRL_IRQ_EN_BIT]     = ctrl_q.irq_en;
      end
      TMR_PRESC_OFFS:   reg_rd = 32'(presc_q);
      TMR_COUNT_OFFS:   reg_rd = count_q;
      TMR_COMPARE_OFFS: reg_rd = compare_q;
      TMR_STATUS_OFFS: begin
        reg_rd[TMR_STATUS_MATCH_BIT] = match_q;
        reg_rd[TMR_STATUS_CAPT_BIT]  = capt_rd;
      end
      TMR_CAPTURE_OFFS: reg_rd = capture_rd;
      default:          reg_rd = '0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    wr_merged = tmr_apply_be(reg_rd, bus_wdata_bi, bus_be_bi);
    hit       = tick & (count_q == compare_q);
    presc_clr = wr_en & (reg_offs == TMR_PRESC_OFFS);
    clr_match = wr_en & (reg_offs == TMR_STATUS_OFFS) & bus_be_bi[0]
                & bus_wdata_bi[TMR_STATUS_MATCH_BIT];

    if (tick) count_d = (hit & ctrl_q.autoreload) ? '0 : count_q + 32'd1;

    // Bus writes come last so a written COUNT overrides the tick update.
    if (wr_en) begin
      case (reg_offs)
        TMR_CTRL_OFFS: begin
          ctrl_d.en         = wr_merged[TMR_CTRL_EN_BIT];
          ctrl_d.autoreload = wr_merged[TMR_CTRL_AUTORELOAD_BIT];
          ctrl_d.irq_en     = wr_merged[TMR_CTRL_IRQ_EN_BIT];
        end
        TMR_PRESC_OFFS:   presc_d   = wr_merged[PRESC_W-1:0];
        TMR_COUNT_OFFS:   count_d   = wr_merged;
        TMR_COMPARE_OFFS: compare_d = wr_merged;
        default: ;
      endcase
    end

    match_d = (match_q & ~clr_match) | hit;
    resp_d  = rd_en;
    rdata_d = rd_en ? reg_rd : '0;
    irq_d   = match_d & ctrl_d.irq_en;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_sigma_xif_timer.sv
// Directed bench for sigma_xif_timer: register write/readback table plus timing sequences.
module tb_sigma_xif_timer;

  localparam logic [31:0] BASE = 32'h80000010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, ack, resp, irq;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
`ifdef SIGMA_XIF_TIMER_CAPTURE_EN
  logic        cap = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sigma_xif_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
`ifdef SIGMA_XIF_TIMER_CAPTURE_EN
    .capture_i    (cap),
`endif
    .bus_req_i    (req),
    .bus_we_i     (we),
    .bus_addr_bi  (addr),
    .bus_be_bi    (be),
    .bus_wdata_bi (wdata),
    .bus_ack_o    (ack),
    .bus_resp_o   (resp),
    .bus_rdata_bo (rdata),
    .irq_o        (irq)
  );

  typedef struct {
    logic [7:0]  offs;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0;
      we  = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] be_v, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE + 32'(off); be = be_v; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = BASE + 32'(off); be = 4'h0;
    #1;
    check({name, " ack"}, 32'(ack), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    check({name, " resp"}, 32'(resp), 32'd1);
    check(name, rdata, exp);
  endtask

  task automatic oow(input logic [31:0] a, input logic we_v, input string name);
    @(negedge clk);
    req = 1'b1; we = we_v; addr = a; be = 4'hF; wdata = 32'hFFFF_FFFF;
    #1;
    check({name, " ack"}, 32'(ack), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    check({name, " resp"}, 32'(resp), 32'd0);
    check({name, " rdata"}, rdata, 32'd0);
  endtask

  vec_t vecs[12];
  logic early;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;

    vecs[0]  = '{8'h00, 4'hF, 32'hFFFF_FFF6, 32'h0000_0006};
    vecs[1]  = '{8'h04, 4'hF, 32'hDEAD_BEEF, 32'h0000_BEEF};
    vecs[2]  = '{8'h08, 4'hF, 32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{8'h0C, 4'hF, 32'h1122_3344, 32'h1122_3344};
    vecs[4]  = '{8'h0C, 4'h2, 32'hAABB_CCDD, 32'h1122_CC44};
    vecs[5]  = '{8'h04, 4'h2, 32'h0000_5500, 32'h0000_55EF};
    vecs[6]  = '{8'h10, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{8'h14, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{8'h18, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{8'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{8'h00, 4'h1, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{8'h08, 4'h8, 32'hAB00_0000, 32'hAB34_5678};

    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset resp", 32'(resp), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    for (int i = 0; i < 6; i++) rd(8'(4 * i), 32'd0, $sformatf("reset read 0x%02h", 4 * i));

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].offs, vecs[i].be, vecs[i].wdata);
      rd(vecs[i].offs, vecs[i].exp, $sformatf("vec %0d off 0x%02h", i, vecs[i].offs));
    end
    check("irq after table", 32'(irq), 32'd0);

    oow(BASE + 32'h20, 1'b1, "oow+0x20 wr");
    oow(BASE + 32'h20, 1'b0, "oow+0x20 rd");
    oow(BASE - 32'h4,  1'b1, "oow-4 wr");
    oow(BASE - 32'h4,  1'b0, "oow-4 rd");
    rd(8'h08, 32'hAB34_5678, "oow count kept");
    rd(8'h0C, 32'h1122_CC44, "oow compare kept");
    rd(8'h04, 32'h0000_55EF, "oow presc kept");
    rd(8'h00, 32'h0000_0000, "oow ctrl kept");

    // Wrap: tick every cycle, no autoreload, compare 7
    wr(8'h04, 4'hF, 32'd0);
    wr(8'h0C, 4'hF, 32'd7);
    wr(8'h08, 4'hF, 32'hFFFF_FFFF);
    wr(8'h00, 4'hF, 32'h1);
    rd(8'h08, 32'hFFFF_FFFF, "wrap count 0");
    rd(8'h08, 32'h0000_0000, "wrap count 1");
    rd(8'h08, 32'h0000_0001, "wrap count 2");
    for (int i = 0; i < 6; i++) rd(8'h10, 32'd0, $sformatf("wrap no match %0d", i));
    rd(8'h10, 32'd1, "wrap match at 7");
    rd(8'h08, 32'd9, "wrap count continues");
    check("wrap irq disabled", 32'(irq), 32'd0);
    wr(8'h00, 4'hF, 32'h0);
    wr(8'h10, 4'hF, 32'h1);
    rd(8'h10, 32'd0, "wrap match cleared");

    // Periodic match: presc 3, compare 5, autoreload + irq
    wr(8'h08, 4'hF, 32'd0);
    wr(8'h04, 4'hF, 32'd3);
    wr(8'h0C, 4'hF, 32'd5);
    wr(8'h00, 4'hF, 32'h7);
    early = 1'b0;
    if (irq) early = 1'b1;
    for (int i = 0; i < 23; i++) begin
      idle(1);
      if (irq) early = 1'b1;
    end
    check("irq before 24 cycles", 32'(early), 32'd0);
    idle(1);
    check("irq at 24 cycles", 32'(irq), 32'd1);
    rd(8'h08, 32'd0, "autoreload count");
    rd(8'h10, 32'd1, "match status");
    wr(8'h10, 4'hF, 32'h1);
    check("irq after w1c", 32'(irq), 32'd0);
    idle(20);
    wr(8'h10, 4'hF, 32'h1);
    check("set beats w1c", 32'(irq), 32'd1);
    wr(8'h10, 4'hF, 32'h1);
    check("w1c next cycle irq", 32'(irq), 32'd0);
    rd(8'h10, 32'd0, "w1c next cycle match");
    rd(8'h08, 32'd0, "second period count");

    // Bus write to COUNT beats a same-cycle tick
    wr(8'h00, 4'hF, 32'h0);
    wr(8'h04, 4'hF, 32'd0);
    wr(8'h0C, 4'hF, 32'hFFFF_0000);
    wr(8'h10, 4'hF, 32'h1);
    wr(8'h00, 4'hF, 32'h1);
    wr(8'h08, 4'hF, 32'h100);
    rd(8'h08, 32'h100, "count write wins");
    rd(8'h08, 32'h101, "count resumes");

    // Reset asserted with a read in flight
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = BASE + 32'h08;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("reset-cycle read resp", 32'(resp), 32'd0);
    check("reset-cycle read rdata", rdata, 32'd0);
    check("reset-cycle irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h08, 32'd0, "count after reset");
    rd(8'h00, 32'd0, "ctrl after reset");
    rd(8'h0C, 32'd0, "compare after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
